// File: rtl/cdc_pkg.sv
// Shared types and helpers for the pulse-crossing launcher and its companions.
package cdc_pkg;

  typedef enum logic {IDLE, WAIT_ACK} cdc_tx_state_t;

  // Width of a counter that must hold the value n; never narrower than one bit.
  function automatic int tmo_w(input int n);
    int w;
    w = $clog2(n + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/cdc_pulse_tx.sv
// Source-domain launcher for a toggle/ack pulse crossing. Each request pulse
// becomes one flip of req_tgl; pulses arriving while a crossing is in flight
// are counted and launched one at a time once the ack toggle catches up.
module cdc_pulse_tx
  import cdc_pkg::*;
#(
  parameter int PEND_W         = 4,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pulse_in,
  input  logic              ack_tgl,
  input  logic              clr_err,
  output logic              req_tgl,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              overflow,
  output logic              timeout,
  output logic              proto_err
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  cdc_tx_state_t     state;
  cdc_tx_state_t     state_nxt;
  logic              req_nxt;
  logic [PEND_W-1:0] pend_nxt;
  logic              set_ovf;
  logic              set_perr;

  // Queue increment that holds at full scale instead of wrapping.
  function automatic logic [PEND_W-1:0] pend_sat_inc(input logic [PEND_W-1:0] p);
    return (p == PEND_MAX) ? p : p + PEND_W'(1);
  endfunction

  // Next-state, launch and queue bookkeeping.
  always_comb begin
    state_nxt = state;
    req_nxt   = req_tgl;
    pend_nxt  = pending;
    set_ovf   = 1'b0;
    set_perr  = 1'b0;
    case (state)
      IDLE: begin
        // Ack must already match while idle; a mismatch is flagged but the launch still goes out.
        set_perr = (ack_tgl != req_tgl);
        if (pulse_in || (pending != '0)) begin
          req_nxt   = ~req_tgl;
          state_nxt = WAIT_ACK;
          // A fresh pulse replaces the queued entry being launched, so the count only drops without one.
          if (!pulse_in) pend_nxt = pending - PEND_W'(1);
        end
      end
      WAIT_ACK: begin
        if (pulse_in) begin
          if (pending == PEND_MAX) set_ovf = 1'b1;
          pend_nxt = pend_sat_inc(pending);
        end
        // Completion returns to IDLE; the next launch waits for that bubble cycle.
        if (ack_tgl == req_tgl) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, request toggle, queue count and the overflow/protocol sticky flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      req_tgl   <= 1'b0;
      pending   <= '0;
      overflow  <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      req_tgl   <= req_nxt;
      pending   <= pend_nxt;
      overflow  <= set_ovf | (overflow & ~clr_err);
      proto_err <= set_perr | (proto_err & ~clr_err);
    end
  end

  assign busy = (state == WAIT_ACK) || (pending != '0);

  if (TIMEOUT_CYCLES > 0) begin : g_tmo
    localparam int            TW       = tmo_w(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_MAX  = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] tmo_cnt;
    logic          tmo_hit;

    // Fires once, on the WAIT_ACK cycle that brings the count up to the limit without an ack.
    assign tmo_hit = (state == WAIT_ACK) && (state_nxt == WAIT_ACK) && (tmo_cnt == TMO_LAST);

    // Counts unacknowledged WAIT_ACK cycles, saturating at the limit; zeroed whenever idle.
    always_ff @(posedge clk) begin
      if (rst) begin
        tmo_cnt <= '0;
        timeout <= 1'b0;
      end else begin
        if (state != WAIT_ACK)
          tmo_cnt <= '0;
        else if ((state_nxt == WAIT_ACK) && (tmo_cnt != TMO_MAX))
          tmo_cnt <= tmo_cnt + TW'(1);
        timeout <= tmo_hit | (timeout & ~clr_err);
      end
    end
  end else begin : g_no_tmo
    assign timeout = 1'b0;
  end

endmodule

// File: tb/tb_cdc_pulse_tx.sv
// Bench for cdc_pulse_tx: two instances (deep queue without timeout, shallow
// queue with timeout) share request/clear/reset stimulus, each with its own
// ack source emulating the destination domain.
module tb_cdc_pulse_tx;

  logic       clk;
  logic       rst;
  logic       pulse_in;
  logic       clr_err;
  logic       ack_a, ack_b;
  logic       req_a, busy_a, ovf_a, tmo_a, perr_a;
  logic [3:0] pend_a;
  logic       req_b, busy_b, ovf_b, tmo_b, perr_b;
  logic [1:0] pend_b;

  int errs;
  int checks;
  int cyc;

  cdc_pulse_tx #(.PEND_W(4), .TIMEOUT_CYCLES(0)) u_dut_a (
    .clk(clk), .rst(rst), .pulse_in(pulse_in), .ack_tgl(ack_a), .clr_err(clr_err),
    .req_tgl(req_a), .busy(busy_a), .pending(pend_a), .overflow(ovf_a),
    .timeout(tmo_a), .proto_err(perr_a)
  );

  cdc_pulse_tx #(.PEND_W(2), .TIMEOUT_CYCLES(8)) u_dut_b (
    .clk(clk), .rst(rst), .pulse_in(pulse_in), .ack_tgl(ack_b), .clr_err(clr_err),
    .req_tgl(req_b), .busy(busy_b), .pending(pend_b), .overflow(ovf_b),
    .timeout(tmo_b), .proto_err(perr_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Destination emulation: ack is either held at a fixed level or is the
  // request toggle seen ack_dly cycles earlier (hist[i][0] = current cycle).
  logic [31:0] hist [2];
  bit          ack_hold_en [2];
  logic        ack_hold [2];
  int          ack_dly [2];

  // Reference model: in-flight flag, queued count, request level, wait count, flags.
  bit m_fly [2];
  bit m_lvl [2];
  int m_q [2];
  int m_wait [2];
  bit m_ovf [2];
  bit m_tmo [2];
  bit m_perr [2];
  int m_cap [2] = '{15, 3};
  int m_lim [2] = '{0, 8};

  task automatic apply_ack();
    ack_a = ack_hold_en[0] ? ack_hold[0] : hist[0][ack_dly[0]];
    ack_b = ack_hold_en[1] ? ack_hold[1] : hist[1][ack_dly[1]];
  endtask

  task automatic model_step(input int i, input logic ack);
    bit s_ovf, s_tmo, s_perr;
    s_ovf = 0; s_tmo = 0; s_perr = 0;
    if (rst) begin
      m_fly[i] = 0; m_lvl[i] = 0; m_q[i] = 0; m_wait[i] = 0;
      m_ovf[i] = 0; m_tmo[i] = 0; m_perr[i] = 0;
      return;
    end
    if (!m_fly[i]) begin
      s_perr = (ack != m_lvl[i]);
      if (pulse_in || m_q[i] > 0) begin
        m_lvl[i]  = !m_lvl[i];
        m_fly[i]  = 1;
        m_wait[i] = 0;
        if (!pulse_in) m_q[i] = m_q[i] - 1;
      end
    end else begin
      if (pulse_in) begin
        if (m_q[i] == m_cap[i]) s_ovf = 1;
        else m_q[i] = m_q[i] + 1;
      end
      if (ack == m_lvl[i]) m_fly[i] = 0;
      else if (m_lim[i] > 0 && m_wait[i] < m_lim[i]) begin
        m_wait[i] = m_wait[i] + 1;
        if (m_wait[i] == m_lim[i]) s_tmo = 1;
      end
    end
    m_ovf[i]  = s_ovf  | (m_ovf[i]  & !clr_err);
    m_tmo[i]  = s_tmo  | (m_tmo[i]  & !clr_err);
    m_perr[i] = s_perr | (m_perr[i] & !clr_err);
  endtask

  // One clock: model consumes the inputs of the ending cycle, then outputs are
  // sampled 1 time unit after the edge and the ack for the new cycle is formed.
  task automatic tick();
    @(posedge clk);
    model_step(0, ack_a);
    model_step(1, ack_b);
    #1;
    if (rst) begin
      hist[0] = '0;
      hist[1] = '0;
    end else begin
      hist[0] = {hist[0][30:0], req_a};
      hist[1] = {hist[1][30:0], req_b};
    end
    apply_ack();
    cyc++;
  endtask

  task automatic do_reset();
    pulse_in = 0; clr_err = 0;
    ack_hold_en = '{0, 0}; ack_hold = '{0, 0}; ack_dly = '{1, 1};
    rst = 1;
    tick();
    rst = 0;
    apply_ack();
  endtask

  task automatic test_reset();
    pulse_in = 1;
    repeat (3) tick();
    do_reset();
    checks++;
    if ({req_a, busy_a, pend_a, ovf_a, tmo_a, perr_a} !== 9'd0) begin
      errs++;
      $display("FAIL reset_a got=%b want=000000000", {req_a, busy_a, pend_a, ovf_a, tmo_a, perr_a});
    end
    checks++;
    if ({req_b, busy_b, pend_b, ovf_b, tmo_b, perr_b} !== 7'd0) begin
      errs++;
      $display("FAIL reset_b got=%b want=0000000", {req_b, busy_b, pend_b, ovf_b, tmo_b, perr_b});
    end
  endtask

  task automatic test_single();
    do_reset();
    ack_dly[0] = 4;
    apply_ack();
    pulse_in = 1;
    tick();
    pulse_in = 0;
    checks++;
    if (req_a !== 1'b1) begin
      errs++; $display("FAIL single_req_flip got=%b want=1", req_a);
    end
    for (int k = 1; k <= 7; k++) begin
      checks++;
      if (busy_a !== (k <= 5)) begin
        errs++; $display("FAIL single_busy cycle N+%0d got=%b want=%b", k, busy_a, (k <= 5));
      end
      tick();
    end
    checks++;
    if ({req_a, perr_a} !== 2'b10) begin
      errs++; $display("FAIL single_end req/perr got=%b want=10", {req_a, perr_a});
    end
  endtask

  task automatic test_back_to_back();
    int flips, peak;
    logic prev;
    do_reset();
    ack_dly[0] = 6;
    apply_ack();
    flips = 0; peak = 0; prev = req_a;
    for (int k = 0; k < 75; k++) begin
      pulse_in = (k < 5);
      tick();
      if (req_a !== prev) flips++;
      prev = req_a;
      if (int'(pend_a) > peak) peak = int'(pend_a);
    end
    checks++;
    if (peak != 4) begin errs++; $display("FAIL b2b_peak_pending got=%0d want=4", peak); end
    checks++;
    if (flips != 5) begin errs++; $display("FAIL b2b_flips got=%0d want=5", flips); end
    checks++;
    if ({req_a, ovf_a, busy_a} !== 3'b100) begin
      errs++; $display("FAIL b2b_final req/ovf/busy got=%b want=100", {req_a, ovf_a, busy_a});
    end
  endtask

  task automatic test_overflow();
    int flips;
    logic prev;
    do_reset();
    ack_hold_en[1] = 1; ack_hold[1] = 0;
    apply_ack();
    flips = 0; prev = req_b;
    for (int k = 1; k <= 6; k++) begin
      pulse_in = 1;
      tick();
      if (req_b !== prev) flips++;
      prev = req_b;
      if (k == 4) begin
        checks++;
        if ({pend_b, ovf_b} !== 3'b110) begin
          errs++; $display("FAIL ovf_before pend/ovf got=%b want=110", {pend_b, ovf_b});
        end
      end
      if (k == 5) begin
        checks++;
        if ({pend_b, ovf_b} !== 3'b111) begin
          errs++; $display("FAIL ovf_on_5th pend/ovf got=%b want=111", {pend_b, ovf_b});
        end
      end
    end
    pulse_in = 0;
    clr_err = 1;
    tick();
    clr_err = 0;
    checks++;
    if ({pend_b, ovf_b} !== 3'b110) begin
      errs++; $display("FAIL ovf_clear pend/ovf got=%b want=110", {pend_b, ovf_b});
    end
    ack_hold_en[1] = 0; ack_dly[1] = 2;
    apply_ack();
    for (int k = 0; k < 40; k++) begin
      tick();
      if (req_b !== prev) flips++;
      prev = req_b;
    end
    checks++;
    if (flips != 4) begin errs++; $display("FAIL ovf_launches got=%0d want=4", flips); end
    checks++;
    if ({req_b, busy_b, pend_b} !== 4'b0000) begin
      errs++; $display("FAIL ovf_final req/busy/pend got=%b want=0000", {req_b, busy_b, pend_b});
    end
  endtask

  task automatic test_timeout();
    do_reset();
    ack_hold_en[1] = 1; ack_hold[1] = 0;
    apply_ack();
    pulse_in = 1;
    tick();
    pulse_in = 0;
    repeat (7) tick();
    checks++;
    if (tmo_b !== 1'b0) begin errs++; $display("FAIL tmo_early got=%b want=0", tmo_b); end
    tick();
    checks++;
    if (tmo_b !== 1'b1) begin errs++; $display("FAIL tmo_set got=%b want=1", tmo_b); end
    repeat (3) tick();
    checks++;
    if (busy_b !== 1'b1) begin errs++; $display("FAIL tmo_still_waiting busy got=%b want=1", busy_b); end
    ack_hold[1] = 1;
    apply_ack();
    tick();
    checks++;
    if ({busy_b, tmo_b, perr_b} !== 3'b010) begin
      errs++; $display("FAIL tmo_late_ack busy/tmo/perr got=%b want=010", {busy_b, tmo_b, perr_b});
    end
    repeat (4) tick();
    checks++;
    if (tmo_b !== 1'b1) begin errs++; $display("FAIL tmo_sticky got=%b want=1", tmo_b); end
    clr_err = 1;
    tick();
    clr_err = 0;
    checks++;
    if (tmo_b !== 1'b0) begin errs++; $display("FAIL tmo_clear got=%b want=0", tmo_b); end
  endtask

  task automatic test_reset_in_flight();
    do_reset();
    ack_hold_en[0] = 1; ack_hold[0] = 1;
    apply_ack();
    tick();
    ack_hold[0] = 0;
    apply_ack();
    repeat (3) begin
      pulse_in = 1;
      tick();
    end
    pulse_in = 0;
    checks++;
    if ({busy_a, pend_a, perr_a} !== 6'b100101) begin
      errs++; $display("FAIL rif_before busy/pend/perr got=%b want=100101", {busy_a, pend_a, perr_a});
    end
    rst = 1;
    tick();
    rst = 0;
    checks++;
    if ({req_a, busy_a, pend_a, ovf_a, tmo_a, perr_a} !== 9'd0) begin
      errs++; $display("FAIL rif_after got=%b want=000000000", {req_a, busy_a, pend_a, ovf_a, tmo_a, perr_a});
    end
  endtask

  task automatic test_proto_err();
    do_reset();
    ack_hold_en[0] = 1; ack_hold[0] = 1;
    apply_ack();
    tick();
    checks++;
    if ({perr_a, req_a} !== 2'b10) begin
      errs++; $display("FAIL perr_set perr/req got=%b want=10", {perr_a, req_a});
    end
    pulse_in = 1;
    tick();
    pulse_in = 0;
    checks++;
    if ({req_a, busy_a, perr_a} !== 3'b111) begin
      errs++; $display("FAIL perr_launch req/busy/perr got=%b want=111", {req_a, busy_a, perr_a});
    end
    tick();
    clr_err = 1;
    tick();
    clr_err = 0;
    checks++;
    if (perr_a !== 1'b0) begin errs++; $display("FAIL perr_clear got=%b want=0", perr_a); end
    ack_hold[0] = 0;
    apply_ack();
    clr_err = 1;
    tick();
    clr_err = 0;
    checks++;
    if (perr_a !== 1'b1) begin errs++; $display("FAIL perr_set_beats_clr got=%b want=1", perr_a); end
  endtask

  task automatic test_random();
    logic [8:0] exp_a;
    logic [6:0] exp_b;
    do_reset();
    for (int k = 0; k < 2000; k++) begin
      pulse_in = ($urandom_range(99) < 40);
      clr_err  = ($urandom_range(99) < 4);
      rst      = ($urandom_range(999) < 8);
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(99) < 2) begin
          ack_hold_en[i] = !ack_hold_en[i];
          ack_hold[i] = 1'($urandom_range(1));
        end
        if ($urandom_range(99) < 3) ack_dly[i] = $urandom_range(8);
      end
      apply_ack();
      tick();
      exp_a = {m_lvl[0], (m_fly[0] || m_q[0] != 0), 4'(m_q[0]), m_ovf[0], m_tmo[0], m_perr[0]};
      exp_b = {m_lvl[1], (m_fly[1] || m_q[1] != 0), 2'(m_q[1]), m_ovf[1], m_tmo[1], m_perr[1]};
      checks++;
      if ({req_a, busy_a, pend_a, ovf_a, tmo_a, perr_a} !== exp_a) begin
        errs++;
        $display("FAIL rand_a cyc=%0d got=%b want=%b", cyc, {req_a, busy_a, pend_a, ovf_a, tmo_a, perr_a}, exp_a);
      end
      checks++;
      if ({req_b, busy_b, pend_b, ovf_b, tmo_b, perr_b} !== exp_b) begin
        errs++;
        $display("FAIL rand_b cyc=%0d got=%b want=%b", cyc, {req_b, busy_b, pend_b, ovf_b, tmo_b, perr_b}, exp_b);
      end
    end
    rst = 0; pulse_in = 0; clr_err = 0;
  endtask

  initial begin
    errs = 0; checks = 0; cyc = 0;
    rst = 1; pulse_in = 0; clr_err = 0;
    hist[0] = '0; hist[1] = '0;
    ack_hold_en = '{0, 0}; ack_hold = '{0, 0}; ack_dly = '{1, 1};
    apply_ack();
    test_reset();
    test_single();
    test_back_to_back();
    test_overflow();
    test_timeout();
    test_reset_in_flight();
    test_proto_err();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
